// File: rtl/reg_bank_loader.sv
// reg_bank_loader: streams upstream words into a one-hot addressed register bank.
// A sequence starts in IDLE on start (length sampled from len, 0 or >64 means 64).
// In LOAD every valid/ready handshake without abort produces, one cycle later, a
// write strobe (en one-hot at the current pointer, cs=1, din=captured word).
// After the last word the FSM spends one FLUSH cycle (final strobe) and one DONE
// cycle (done pulse) before returning to IDLE. abort in LOAD drops back to IDLE.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, len        sequence start and requested length (sampled in IDLE)
//   abort             terminates an active load
//   s_valid, s_data   upstream word stream
//   s_ready           registered: high only while in LOAD
//   en, cs, din       registered bank write strobe, chip select and data
//   busy, done        registered: in progress (LOAD/FLUSH), completion pulse
module reg_bank_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [6:0]            len,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [NUM_REGS-1:0]   en,
  output logic                  cs,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PTR_W = 6;
  localparam int unsigned LEN_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [LEN_W-1:0]   len_q;

  logic               hs_c;
  logic               last_c;
  logic [LEN_W-1:0]   eff_len_c;

  // s_ready is a registered copy of "state is LOAD", so it qualifies the handshake.
  assign hs_c      = s_ready && s_valid && !abort;
  assign last_c    = ({1'b0, ptr} == (len_q - LEN_W'(1)));
  assign eff_len_c = ((len == '0) || (len > LEN_W'(NUM_REGS))) ? LEN_W'(NUM_REGS) : len;

  // Sequence FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      len_q   <= LEN_W'(NUM_REGS);
      s_ready <= 1'b0;
      en      <= '0;
      cs      <= 1'b0;
      din     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      en   <= '0;
      cs   <= 1'b0;
      done <= 1'b0;

      // Strobe for the word accepted on the previous cycle.
      if (hs_c) begin
        en  <= NUM_REGS'(1) << ptr;
        cs  <= 1'b1;
        din <= s_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            ptr     <= '0;
            len_q   <= eff_len_c;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (s_valid) begin
            // Pointer stops at the last index so it never wraps past 63.
            if (last_c) begin
              state   <= FLUSH;
              s_ready <= 1'b0;
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
          end
        end
        FLUSH: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
